bb_jtag_channel_mux: RTL and testbench
======================================

// Module: bb_jtag_channel_mux
// PURPOSE
//  Next-generation BusBlaster CPLD passthrough: routes one FT2232 MPSSE JTAG port to NUM_CH target
//  connectors. TCK/TDI/TMS/TDO stay combinational to the active channel (zero latency). A clocked
//  control path tracks TAP state and switches channels only at safe TAP states. It also generates
//  stretched nSRST/nTRST pulses, debounces BUTTON and drives an activity LED.
// PARAMETERS
//  NUM_CH           2      target JTAG channels (2..8); SEL_W = max(1,$clog2(NUM_CH))
//  DEBOUNCE_CYCLES  50000  BUTTON level must be stable this many CLK cycles before it is accepted
//  SRST_CYCLES      100000 nSRST assertion length, CLK cycles
//  TRST_CYCLES      1000   nTRST assertion length after reset release, CLK cycles
//  LED_HOLD_CYCLES  2000000 LED on-time after last TCK rising edge, CLK cycles
// PORTS
//  CLK          in  1          system clock; all state on rising edge
//  nRST         in  1          synchronous, active-low reset
//  FT_TCK/FT_TDI/FT_TMS in 1   from FT2232 ADBUS
//  FT_TDO       out 1          TDO of active channel (combinational)
//  FT_SEL       in  SEL_W      requested channel (GPIOH)
//  FT_SRST_REQ  in  1          rising edge requests nSRST pulse on active channel
//  TCK/TDI/TMS  out NUM_CH     per-channel target drives
//  TDO          in  NUM_CH     per-channel target TDO
//  nTRST        out NUM_CH     per-channel test reset, active low
//  nSRST_OE     out NUM_CH     1 = pull nSRST low (open-drain enable)
//  BUTTON       in  1          raw push button, active high
//  LED          out 1          activity indicator
//  ACTIVE_CH    out SEL_W      currently routed channel
//  TAP_STATE    out 4          tracked TAP state of active channel
// BEHAVIOUR
//  - Reset: ACTIVE_CH=0, TAP_STATE=TLR for all channels, nSRST_OE=0, LED=0, nTRST=0 on all
//    channels. After nRST deasserts, nTRST stays 0 for TRST_CYCLES, then goes 1.
//  - Routing: the active channel gets TCK=FT_TCK, TDI=FT_TDI, TMS=FT_TMS, FT_TDO=TDO[act].
//    Inactive channels hold TCK=0, TMS=1, TDI=0. FT_SEL out of range is ignored (stays pending).
//  - FT_TCK/FT_TMS/FT_SRST_REQ/BUTTON pass through 2-FF synchronisers. A TCK rising edge is a
//    synced 0->1 transition; on that cycle the tracker steps the 16-state IEEE 1149.1 FSM using
//    synced TMS. Encoding: TLR=0 RTI=1 SELDR=2 CAPDR=3 SHDR=4 EX1DR=5 PDR=6 EX2DR=7 UPDR=8
//    SELIR=9 CAPIR=A SHIR=B EX1IR=C PIR=D EX2IR=E UPIR=F.
//  - Per-channel state array: the active entry is updated; inactive entries are frozen. This is
//    valid because inactive targets see no TCK edges.
//  - Switch: when FT_SEL != ACTIVE_CH, the switch is pending. It is accepted on the first cycle
//    that meets all of: TAP_STATE in {TLR,RTI}; no TCK edge in that cycle; synced FT_TCK=0.
//    ACTIVE_CH updates the next cycle and TAP_STATE shows the restored entry. If FT_SEL changes
//    again while pending, the latest value wins.
//  - nSRST: a synced FT_SRST_REQ rising edge or a debounced BUTTON press sets nSRST_OE[act]=1 for
//    SRST_CYCLES. A retrigger during the pulse reloads the counter. A channel switch is blocked
//    while a pulse is active. During the pulse the tracker is unaffected (SRST does not reset TAP).
//  - LED: on while the hold counter is nonzero. Each TCK edge reloads it with LED_HOLD_CYCLES.
//    LED is also forced on while any nSRST_OE is set.
//  - Counters saturate at 0. nRST low mid-pulse aborts all pulses immediately (next edge).
// CONFIGURATION
//  BB_JTAG_RTCK_EN defined: adds RTCK in NUM_CH and FT_RTCK out 1.
//    - FT_RTCK = 2-FF synced RTCK[act].
//    - Switch acceptance additionally requires synced RTCK[act]==0.
//  BB_JTAG_RTCK_EN undefined: those ports are absent and switch gating ignores RTCK.
// STRUCTURE
//  - Package bb_jtag_pkg holds:
//    - tap_state_t: 4-bit enum with the encoding above.
//    - the next-state function tap_next(state, tms).
//    - the TAP_TLR/TAP_RTI constants.
//  - Sub-module bb_debounce (param CYCLES): sync + stable counter + rising-edge pulse output.
//    It is used for BUTTON.
//  - Routing, tracker, switch control, pulse counters and LED stay in this module.
// TESTING
//  - Reset release -> nTRST=0 for exactly TRST_CYCLES (set to 8), then 1; ACTIVE_CH=0, TAP_STATE=0.
//  - 5 TCK pulses, TMS=0 then TMS=1,0,0 -> TAP_STATE sequence reaches SHDR (4); ch1 TCK stays 0.
//  - In SHDR, set FT_SEL=1 -> no switch. Clock TMS=1,1,0 to RTI -> ACTIVE_CH=1 within 2 cycles.
//    TAP_STATE=TLR (ch1 entry); back to ch0 restores RTI.
//  - FT_SRST_REQ pulse (SRST_CYCLES=20) -> nSRST_OE[act]=1 for 20 cycles, LED=1. Retrigger at
//    cycle 10 -> 30 cycles total.
//  - BUTTON bounce 3 cycles then steady high (DEBOUNCE_CYCLES=16) -> one nSRST pulse, not three.
//  - BB_JTAG_RTCK_EN: hold RTCK[act]=1 with FT_SEL pending in TLR -> no switch until RTCK=0.
//    FT_RTCK lags RTCK by 2 cycles.

Source files
------------

// File: rtl/bb_jtag_pkg.sv
// Shared TAP controller types and the IEEE 1149.1 next-state function.
package bb_jtag_pkg;

  typedef enum logic [3:0] {
    TapTlr   = 4'h0,
    TapRti   = 4'h1,
    TapSelDr = 4'h2,
    TapCapDr = 4'h3,
    TapShDr  = 4'h4,
    TapEx1Dr = 4'h5,
    TapPDr   = 4'h6,
    TapEx2Dr = 4'h7,
    TapUpDr  = 4'h8,
    TapSelIr = 4'h9,
    TapCapIr = 4'hA,
    TapShIr  = 4'hB,
    TapEx1Ir = 4'hC,
    TapPIr   = 4'hD,
    TapEx2Ir = 4'hE,
    TapUpIr  = 4'hF
  } tap_state_t;

  localparam tap_state_t TAP_TLR = TapTlr;
  localparam tap_state_t TAP_RTI = TapRti;

  function automatic tap_state_t tap_next(input tap_state_t state, input logic tms);
    tap_state_t nxt;
    nxt = TapTlr;
    case (state)
      TapTlr:   nxt = tms ? TapTlr   : TapRti;
      TapRti:   nxt = tms ? TapSelDr : TapRti;
      TapSelDr: nxt = tms ? TapSelIr : TapCapDr;
      TapCapDr: nxt = tms ? TapEx1Dr : TapShDr;
      TapShDr:  nxt = tms ? TapEx1Dr : TapShDr;
      TapEx1Dr: nxt = tms ? TapUpDr  : TapPDr;
      TapPDr:   nxt = tms ? TapEx2Dr : TapPDr;
      TapEx2Dr: nxt = tms ? TapUpDr  : TapShDr;
      TapUpDr:  nxt = tms ? TapSelDr : TapRti;
      TapSelIr: nxt = tms ? TapTlr   : TapCapIr;
      TapCapIr: nxt = tms ? TapEx1Ir : TapShIr;
      TapShIr:  nxt = tms ? TapEx1Ir : TapShIr;
      TapEx1Ir: nxt = tms ? TapUpIr  : TapPIr;
      TapPIr:   nxt = tms ? TapEx2Ir : TapPIr;
      TapEx2Ir: nxt = tms ? TapUpIr  : TapShIr;
      TapUpIr:  nxt = tms ? TapSelDr : TapRti;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bb_debounce.sv
// Button debouncer: 2-FF synchroniser, stable-level counter, one-cycle pulse on accepted rise.
module bb_debounce #(
  parameter int unsigned CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse
);

  localparam int unsigned CNT_W = $clog2(CYCLES + 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             pulse_q;
  logic [CNT_W-1:0] cnt_q;

  // The counter only runs while the synced input disagrees with the accepted level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      pulse_q <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(CYCLES - 1)) begin
        level_q <= sync2_q;
        pulse_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/bb_jtag_channel_mux.sv
// FT2232 JTAG passthrough to NUM_CH targets with TAP-safe channel switching and reset pulses.
// Optional BB_JTAG_RTCK_EN adds RTCK inputs, FT_RTCK output and RTCK-gated switching.
module bb_jtag_channel_mux
  import bb_jtag_pkg::*;
#(
  parameter int unsigned NUM_CH          = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned SRST_CYCLES     = 100000,
  parameter int unsigned TRST_CYCLES     = 1000,
  parameter int unsigned LED_HOLD_CYCLES = 2000000,
  localparam int unsigned SEL_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              FT_TCK,
  input  logic              FT_TDI,
  input  logic              FT_TMS,
  output logic              FT_TDO,
  input  logic [SEL_W-1:0]  FT_SEL,
  input  logic              FT_SRST_REQ,
  output logic [NUM_CH-1:0] TCK,
  output logic [NUM_CH-1:0] TDI,
  output logic [NUM_CH-1:0] TMS,
  input  logic [NUM_CH-1:0] TDO,
  output logic [NUM_CH-1:0] nTRST,
  output logic [NUM_CH-1:0] nSRST_OE,
  input  logic              BUTTON,
  output logic              LED,
  output logic [SEL_W-1:0]  ACTIVE_CH,
`ifdef BB_JTAG_RTCK_EN
  input  logic [NUM_CH-1:0] RTCK,
  output logic              FT_RTCK,
`endif
  output logic [3:0]        TAP_STATE
);

  localparam int unsigned TRST_W = $clog2(TRST_CYCLES + 1);
  localparam int unsigned SRST_W = $clog2(SRST_CYCLES + 1);
  localparam int unsigned LED_W  = $clog2(LED_HOLD_CYCLES + 1);

  logic              tck_s1_q, tck_s2_q, tck_prev_q;
  logic              tms_s1_q, tms_s2_q;
  logic              req_s1_q, req_s2_q, req_prev_q;
  logic [SEL_W-1:0]  active_q;
  tap_state_t        tap_q [NUM_CH];
  tap_state_t        tap_cur;
  logic [TRST_W-1:0] trst_cnt_q;
  logic [SRST_W-1:0] srst_cnt_q;
  logic [LED_W-1:0]  led_cnt_q;

  logic tck_edge, srst_trig, srst_on, btn_pulse, pending, tap_safe, rtck_busy, accept;

  bb_debounce #(
    .CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk  (CLK),
    .rst_n(nRST),
    .raw  (BUTTON),
    .pulse(btn_pulse)
  );

`ifdef BB_JTAG_RTCK_EN
  logic rtck_s1_q, rtck_s2_q;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rtck_s1_q <= 1'b0;
      rtck_s2_q <= 1'b0;
    end else begin
      rtck_s1_q <= RTCK[active_q];
      rtck_s2_q <= rtck_s1_q;
    end
  end

  assign FT_RTCK   = rtck_s2_q;
  assign rtck_busy = rtck_s2_q;
`else
  assign rtck_busy = 1'b0;
`endif

  assign tap_cur = tap_q[active_q];

  always_comb begin
    tck_edge  = tck_s2_q & ~tck_prev_q;
    srst_trig = (req_s2_q & ~req_prev_q) | btn_pulse;
    srst_on   = (srst_cnt_q != '0);
    pending   = (32'(FT_SEL) < NUM_CH) && (FT_SEL != active_q);
    tap_safe  = (tap_cur == TAP_TLR) || (tap_cur == TAP_RTI);
    // A pulse being started this cycle also blocks, so it lands on the channel that asked.
    accept    = pending && tap_safe && !tck_edge && !tck_s2_q && !srst_on && !srst_trig &&
                !rtck_busy;
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      TCK[i]      = (active_q == SEL_W'(i)) & FT_TCK;
      TDI[i]      = (active_q == SEL_W'(i)) & FT_TDI;
      TMS[i]      = (active_q == SEL_W'(i)) ? FT_TMS : 1'b1;
      nSRST_OE[i] = (active_q == SEL_W'(i)) & srst_on;
      nTRST[i]    = (trst_cnt_q == '0);
    end
    FT_TDO = TDO[active_q];
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      tck_s1_q   <= 1'b0;
      tck_s2_q   <= 1'b0;
      tck_prev_q <= 1'b0;
      tms_s1_q   <= 1'b0;
      tms_s2_q   <= 1'b0;
      req_s1_q   <= 1'b0;
      req_s2_q   <= 1'b0;
      req_prev_q <= 1'b0;
      active_q   <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) tap_q[i] <= TAP_TLR;
      trst_cnt_q <= TRST_W'(TRST_CYCLES);
      srst_cnt_q <= '0;
      led_cnt_q  <= '0;
    end else begin
      tck_s1_q   <= FT_TCK;
      tck_s2_q   <= tck_s1_q;
      tck_prev_q <= tck_s2_q;
      tms_s1_q   <= FT_TMS;
      tms_s2_q   <= tms_s1_q;
      req_s1_q   <= FT_SRST_REQ;
      req_s2_q   <= req_s1_q;
      req_prev_q <= req_s2_q;

      // Inactive targets see no TCK, so only the active entry ever advances.
      if (tck_edge) tap_q[active_q] <= tap_next(tap_cur, tms_s2_q);
      if (accept) active_q <= FT_SEL;

      if (trst_cnt_q != '0) trst_cnt_q <= trst_cnt_q - 1'b1;

      if (srst_trig) srst_cnt_q <= SRST_W'(SRST_CYCLES);
      else if (srst_on) srst_cnt_q <= srst_cnt_q - 1'b1;

      if (tck_edge) led_cnt_q <= LED_W'(LED_HOLD_CYCLES);
      else if (led_cnt_q != '0) led_cnt_q <= led_cnt_q - 1'b1;
    end
  end

  assign LED       = (led_cnt_q != '0) | srst_on;
  assign ACTIVE_CH = active_q;
  assign TAP_STATE = tap_cur;

endmodule

// File: tb/tb_bb_jtag_channel_mux.sv
// Scoreboard bench: a cycle model pushes expected state each clock, a monitor pops and compares.
module tb_bb_jtag_channel_mux;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned DEB    = 16;
  localparam int unsigned SRST   = 20;
  localparam int unsigned TRST   = 8;
  localparam int unsigned HOLD   = 40;

  logic              CLK = 1'b0;
  logic              nRST = 1'b0;
  logic              FT_TCK = 1'b0, FT_TDI = 1'b0, FT_TMS = 1'b1, FT_SRST_REQ = 1'b0;
  logic              BUTTON = 1'b0;
  logic [SEL_W-1:0]  FT_SEL = '0;
  logic [NUM_CH-1:0] TDO = '0;
  logic              FT_TDO, LED;
  logic [NUM_CH-1:0] TCK, TDI, TMS, nTRST, nSRST_OE;
  logic [SEL_W-1:0]  ACTIVE_CH;
  logic [3:0]        TAP_STATE;
`ifdef BB_JTAG_RTCK_EN
  logic [NUM_CH-1:0] RTCK = '0;
  logic              FT_RTCK;
`endif

  bb_jtag_channel_mux #(
    .NUM_CH(NUM_CH), .DEBOUNCE_CYCLES(DEB), .SRST_CYCLES(SRST), .TRST_CYCLES(TRST),
    .LED_HOLD_CYCLES(HOLD)
  ) dut (
    .CLK(CLK), .nRST(nRST), .FT_TCK(FT_TCK), .FT_TDI(FT_TDI), .FT_TMS(FT_TMS),
    .FT_TDO(FT_TDO), .FT_SEL(FT_SEL), .FT_SRST_REQ(FT_SRST_REQ), .TCK(TCK), .TDI(TDI),
    .TMS(TMS), .TDO(TDO), .nTRST(nTRST), .nSRST_OE(nSRST_OE), .BUTTON(BUTTON), .LED(LED),
    .ACTIVE_CH(ACTIVE_CH),
`ifdef BB_JTAG_RTCK_EN
    .RTCK(RTCK), .FT_RTCK(FT_RTCK),
`endif
    .TAP_STATE(TAP_STATE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [SEL_W-1:0] act;
    logic [3:0]       tap;
    logic             trst_done;
    logic             srst_on;
    logic             led;
`ifdef BB_JTAG_RTCK_EN
    logic             rtck;
`endif
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // IEEE 1149.1 transition table, indexed by state, for TMS=0 and TMS=1.
  int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, want);
    end
  endtask

  // Reference model: synchronisers are pure 2-cycle delays; everything else follows the rules.
  int       m_act, trst_left, srst_left, led_left, b_run;
  int       m_tap [NUM_CH];
  bit [2:0] tck_d, req_d;
  bit [1:0] tms_d, btn_d, rt_d;
  bit       b_last, b_filt, b_pulse;

  always @(posedge CLK) begin : model
    bit   edge_ev, trig, pend, accept;
    exp_t e;
    if (!nRST) begin
      m_act = 0;
      foreach (m_tap[i]) m_tap[i] = 0;
      trst_left = TRST; srst_left = 0; led_left = 0;
      tck_d = '0; req_d = '0; tms_d = '0; btn_d = '0; rt_d = '0;
      b_run = 0; b_last = 0; b_filt = 0; b_pulse = 0;
    end else begin
      edge_ev = tck_d[1] && !tck_d[2];
      trig    = (req_d[1] && !req_d[2]) || b_pulse;
      pend    = (int'(FT_SEL) != m_act) && (int'(FT_SEL) < int'(NUM_CH));
      accept  = pend && (m_tap[m_act] <= 1) && !tck_d[1] && (srst_left == 0) && !trig;
`ifdef BB_JTAG_RTCK_EN
      accept  = accept && !rt_d[1];
      rt_d    = {rt_d[0], RTCK[m_act]};
`endif
      if (edge_ev) m_tap[m_act] = tms_d[1] ? nxt1[m_tap[m_act]] : nxt0[m_tap[m_act]];
      if (accept) m_act = int'(FT_SEL);
      srst_left = trig ? SRST : (srst_left > 0 ? srst_left - 1 : 0);
      led_left  = edge_ev ? HOLD : (led_left > 0 ? led_left - 1 : 0);
      if (trst_left > 0) trst_left--;
      // Button level is accepted once the synced value has held for DEB samples.
      b_pulse = 0;
      b_run   = (btn_d[1] == b_last) ? b_run + 1 : 1;
      b_last  = btn_d[1];
      if (b_run >= int'(DEB) && btn_d[1] != b_filt) begin
        b_filt  = btn_d[1];
        b_pulse = b_filt;
      end
      tck_d = {tck_d[1:0], FT_TCK};
      req_d = {req_d[1:0], FT_SRST_REQ};
      tms_d = {tms_d[0], FT_TMS};
      btn_d = {btn_d[0], BUTTON};
    end
    e.act       = SEL_W'(m_act);
    e.tap       = 4'(m_tap[m_act]);
    e.trst_done = (trst_left == 0);
    e.srst_on   = (srst_left > 0);
    e.led       = (led_left > 0) || (srst_left > 0);
`ifdef BB_JTAG_RTCK_EN
    e.rtck      = rt_d[1];
`endif
    sb_q.push_back(e);
  end

  always @(negedge CLK) begin : monitor
    exp_t              e;
    logic [NUM_CH-1:0] xt, xd, xm, xs;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      for (int i = 0; i < int'(NUM_CH); i++) begin
        xt[i] = (i == int'(e.act)) ? FT_TCK : 1'b0;
        xd[i] = (i == int'(e.act)) ? FT_TDI : 1'b0;
        xm[i] = (i == int'(e.act)) ? FT_TMS : 1'b1;
        xs[i] = (i == int'(e.act)) && e.srst_on;
      end
      chk("active_ch", 32'(ACTIVE_CH), 32'(e.act));
      chk("tap_state", 32'(TAP_STATE), 32'(e.tap));
      chk("ntrst", 32'(nTRST), e.trst_done ? 32'((1 << NUM_CH) - 1) : 32'd0);
      chk("nsrst_oe", 32'(nSRST_OE), 32'(xs));
      chk("led", 32'(LED), 32'(e.led));
      chk("tck", 32'(TCK), 32'(xt));
      chk("tdi", 32'(TDI), 32'(xd));
      chk("tms", 32'(TMS), 32'(xm));
      chk("ft_tdo", 32'(FT_TDO), 32'(TDO[e.act]));
`ifdef BB_JTAG_RTCK_EN
      chk("ft_rtck", 32'(FT_RTCK), 32'(e.rtck));
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic tck_pulse(input logic tms);
    FT_TMS = tms;
    FT_TCK = 1'b0; tick(3);
    FT_TCK = 1'b1; tick(3);
    FT_TCK = 1'b0; tick(3);
  endtask

  // Runs n cycles and adds the cycles where channel 0 drives nSRST.
  task automatic run_count(input int n, inout int hi);
    repeat (n) begin
      tick(1);
      if (nSRST_OE[0]) hi++;
    end
  endtask

  initial begin : stim
    int hi;
    TDO = 3'b101;
    tick(4);
    nRST = 1'b1;
    tick(TRST - 1);
    chk("trst_held", 32'(nTRST), 32'd0);
    tick(1);
    chk("trst_release", 32'(nTRST), 32'h7);

    // TLR -> RTI -> RTI -> SELDR -> CAPDR -> SHDR
    tck_pulse(1'b0); tck_pulse(1'b0); tck_pulse(1'b1); tck_pulse(1'b0); tck_pulse(1'b0);
    chk("walk_shdr", 32'(TAP_STATE), 32'd4);
    FT_SEL = 2'd1;
    tick(6);
    chk("no_switch_shdr", 32'(ACTIVE_CH), 32'd0);
    tck_pulse(1'b1); tck_pulse(1'b1); tck_pulse(1'b0);
    tick(2);
    chk("switch_at_rti", 32'(ACTIVE_CH), 32'd1);
    chk("ch1_tlr", 32'(TAP_STATE), 32'd0);
    FT_SEL = 2'd0;
    tick(4);
    chk("ch0_restored", 32'(TAP_STATE), 32'd1);
    FT_SEL = 2'd3;
    tick(6);
    chk("sel_out_of_range", 32'(ACTIVE_CH), 32'd0);
    FT_SEL = 2'd0;

    // Request pulse, then retrigger ten cycles after the first request edge.
    hi = 0;
    FT_SRST_REQ = 1'b1; run_count(2, hi);
    FT_SRST_REQ = 1'b0; run_count(8, hi);
    FT_SRST_REQ = 1'b1; run_count(2, hi);
    FT_SRST_REQ = 1'b0; run_count(40, hi);
    chk("srst_retrigger_len", 32'(hi), 32'd30);

    // Bouncy press gives one pulse; release gives none.
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      BUTTON = ~BUTTON;
      run_count(1, hi);
    end
    BUTTON = 1'b1; run_count(60, hi);
    BUTTON = 1'b0; run_count(40, hi);
    chk("button_one_pulse", 32'(hi), 32'(SRST));

`ifdef BB_JTAG_RTCK_EN
    RTCK = 3'b001;
    tick(4);
    FT_SEL = 2'd2;
    tick(8);
    chk("rtck_blocks_switch", 32'(ACTIVE_CH), 32'd0);
    RTCK = 3'b000;
    tick(5);
    chk("rtck_release_switch", 32'(ACTIVE_CH), 32'd2);
`endif

    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 99) < 35) FT_TCK = ~FT_TCK;
      FT_TMS = ($urandom_range(0, 99) < 45);
      FT_TDI = 1'($urandom);
      TDO    = NUM_CH'($urandom);
      if ($urandom_range(0, 99) < 5) FT_SEL = SEL_W'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 3) FT_SRST_REQ = ~FT_SRST_REQ;
      if ($urandom_range(0, 99) < 3) BUTTON = ~BUTTON;
`ifdef BB_JTAG_RTCK_EN
      if ($urandom_range(0, 99) < 10) RTCK = NUM_CH'($urandom);
`endif
      if ($urandom_range(0, 399) == 0) begin
        nRST = 1'b0;
        tick($urandom_range(1, 4));
        nRST = 1'b1;
      end
      tick(1);
    end
    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
